// File: rtl/fp_addsub.sv
// Multi-cycle IEEE-754 style floating-point adder/subtractor.
// One operation in flight; the FSM walks a fixed sequence of datapath steps
// and holds the result until the consumer takes it.
//
// state  | meaning
// IDLE   | ready for a new operation, operands latched on accept
// UNPACK | split fields, apply subtract sign flip, classify NaN/inf
// ALIGN  | order operands by magnitude, shift smaller with guard/round/sticky
// ADD    | add or subtract magnitudes, pick result sign
// NORM   | normalise (right by one on carry, else left by lzc, exp floor 1)
// ROUND  | round to nearest even, resolve overflow and special results
// OUT    | present z/flags, wait for the consumer handshake
module fp_addsub #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic                 op_sub,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [EXP_W+MAN_W:0] z,
    output logic                 z_valid,
    input  logic                 z_ready,
    output logic [2:0]           flags
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int NW = MAN_W + 4;   // hidden + fraction + guard/round/sticky
    localparam int EW = EXP_W + 7;   // working exponent, also wide enough for shift counts
    localparam logic [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
    localparam logic [W-1:0]  QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, OUT} state_t;

    state_t state_q, state_d;

    logic [W-1:0]     a_q, b_q;
    logic             op_q;
    logic             sa_q, sb_q, spec_q;
    logic [EW-1:0]    ea_q, eb_q;
    logic [MAN_W:0]   ma_q, mb_q;
    logic [W-1:0]     spec_z_q;
    logic [2:0]       spec_f_q;
    logic             sl_q, ss_q;
    logic [EW-1:0]    el_q;
    logic [NW-1:0]    gl_q, gs_q;
    logic [NW:0]      sum_q;
    logic             sgn_q;
    logic [EW-1:0]    en_q;
    logic [NW-1:0]    ns_q;
    logic [W-1:0]     res_z_q;
    logic [2:0]       res_f_q;
    logic             z_valid_q;

    // unpack stage signals
    logic [EXP_W-1:0] xa, xb;
    logic [MAN_W-1:0] fa, fb;
    logic             sa_d, sb_d;
    logic [EW-1:0]    ea_d, eb_d;
    logic [MAN_W:0]   ma_d, mb_d;
    logic             nan_a, nan_b, snan_a, snan_b, inf_a, inf_b;
    logic             spec_d;
    logic [W-1:0]     spec_z_d;
    logic [2:0]       spec_f_d;

    // align stage signals
    logic             a_ge;
    logic             sl_d, ss_d;
    logic [EW-1:0]    el_d, diff, sh;
    logic [NW-1:0]    gl_d, gs_d, sm_ext, sm_shift;
    logic             lost;

    // add / norm / round stage signals
    logic [NW:0]      sum_d;
    logic             sgn_d;
    logic [EW-1:0]    en_d, lz, lim, amt;
    logic [NW-1:0]    ns_d;
    logic             rnd_up, inexact;
    logic [MAN_W+1:0] mr;
    logic [MAN_W:0]   mf;
    logic [EW-1:0]    ef;
    logic [W-1:0]     res_z_d;
    logic [2:0]       res_f_d;

    function automatic logic [EW-1:0] lzc(input logic [NW-1:0] v);
        logic [EW-1:0] n;
        n = EW'(NW);
        for (int i = 0; i < NW; i++) begin
            if (v[i]) n = EW'(NW - 1 - i);
        end
        return n;
    endfunction

    assign in_ready = (state_q == IDLE);
    assign z_valid  = z_valid_q;
    assign z        = res_z_q;
    assign flags    = res_f_q;

    // Field split, denormal handling and NaN/infinity classification.
    always_comb begin
        xa     = a_q[W-2:MAN_W];
        xb     = b_q[W-2:MAN_W];
        fa     = a_q[MAN_W-1:0];
        fb     = b_q[MAN_W-1:0];
        sa_d   = a_q[W-1];
        sb_d   = b_q[W-1] ^ op_q;
        ea_d   = (xa == '0) ? EW'(1) : EW'(xa);
        eb_d   = (xb == '0) ? EW'(1) : EW'(xb);
        ma_d   = {(xa != '0), fa};
        mb_d   = {(xb != '0), fb};
        nan_a  = (&xa) && (|fa);
        nan_b  = (&xb) && (|fb);
        snan_a = nan_a && !fa[MAN_W-1];
        snan_b = nan_b && !fb[MAN_W-1];
        inf_a  = (&xa) && !(|fa);
        inf_b  = (&xb) && !(|fb);
        spec_d   = 1'b0;
        spec_z_d = '0;
        spec_f_d = 3'b000;
        if (nan_a || nan_b) begin
            spec_d   = 1'b1;
            spec_z_d = QNAN;
            spec_f_d = {(snan_a || snan_b), 2'b00};
        end else if (inf_a && inf_b) begin
            spec_d = 1'b1;
            if (sa_d == sb_d) begin
                spec_z_d = {sa_d, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end else begin
                spec_z_d = QNAN;
                spec_f_d = 3'b100;
            end
        end else if (inf_a || inf_b) begin
            spec_d   = 1'b1;
            spec_z_d = {(inf_a ? sa_d : sb_d), {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end
    end

    // Magnitude ordering and single-cycle sticky-preserving alignment shift.
    always_comb begin
        a_ge     = {ea_q, ma_q} >= {eb_q, mb_q};
        el_d     = a_ge ? ea_q : eb_q;
        diff     = a_ge ? (ea_q - eb_q) : (eb_q - ea_q);
        sl_d     = a_ge ? sa_q : sb_q;
        ss_d     = a_ge ? sb_q : sa_q;
        gl_d     = {(a_ge ? ma_q : mb_q), 3'b000};
        sm_ext   = {(a_ge ? mb_q : ma_q), 3'b000};
        sh       = (diff > EW'(NW)) ? EW'(NW) : diff;
        sm_shift = sm_ext >> sh;
        lost     = |(sm_ext & ~({NW{1'b1}} << sh));
        gs_d     = {sm_shift[NW-1:1], sm_shift[0] | lost};
    end

    // Magnitude add/subtract; a zero sum is negative only for (-0)+(-0).
    always_comb begin
        if (sl_q == ss_q) sum_d = {1'b0, gl_q} + {1'b0, gs_q};
        else              sum_d = {1'b0, gl_q} - {1'b0, gs_q};
        sgn_d = (sum_d == '0) ? (sl_q & ss_q) : sl_q;
    end

    // Normalisation; left shift stops at exponent 1 so tiny results stay denormal.
    always_comb begin
        lz  = lzc(sum_q[NW-1:0]);
        lim = el_q - EW'(1);
        amt = (lz < lim) ? lz : lim;
        if (sum_q[NW]) begin
            ns_d = {sum_q[NW:2], sum_q[1] | sum_q[0]};
            en_d = el_q + EW'(1);
        end else begin
            ns_d = sum_q[NW-1:0] << amt;
            en_d = el_q - amt;
        end
    end

    // Round to nearest even, then pick special, overflow or packed finite result.
    always_comb begin
        rnd_up  = ns_q[2] & (ns_q[1] | ns_q[0] | ns_q[3]);
        inexact = |ns_q[2:0];
        mr      = {1'b0, ns_q[NW-1:3]} + (MAN_W+2)'(rnd_up);
        if (mr[MAN_W+1]) begin
            mf = mr[MAN_W+1:1];
            ef = en_q + EW'(1);
        end else begin
            mf = mr[MAN_W:0];
            ef = en_q;
        end
        if (spec_q) begin
            res_z_d = spec_z_q;
            res_f_d = spec_f_q;
        end else if (ef >= EMAX) begin
            res_z_d = {sgn_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            res_f_d = 3'b011;
        end else begin
            res_z_d = {sgn_q, (mf[MAN_W] ? ef[EXP_W-1:0] : {EXP_W{1'b0}}), mf[MAN_W-1:0]};
            res_f_d = {2'b00, inexact};
        end
    end

    // Next-state logic: fixed walk through the datapath steps, handshake in/out.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = UNPACK;
            UNPACK:  state_d = ALIGN;
            ALIGN:   state_d = ADD;
            ADD:     state_d = NORM;
            NORM:    state_d = ROUND;
            ROUND:   state_d = OUT;
            OUT:     if (z_valid_q && z_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register, result registers and output valid; reset discards any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            z_valid_q <= 1'b0;
            res_z_q   <= '0;
            res_f_q   <= 3'b000;
        end else begin
            state_q <= state_d;
            if (state_q == ROUND) begin
                res_z_q <= res_z_d;
                res_f_q <= res_f_d;
            end
            if (state_q == OUT) z_valid_q <= !(z_valid_q && z_ready);
        end
    end

    // Per-step datapath registers, loaded only in the state that produces them.
    always_ff @(posedge clk) begin
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_q  <= a;
                    b_q  <= b;
                    op_q <= op_sub;
                end
            end
            UNPACK: begin
                sa_q     <= sa_d;
                sb_q     <= sb_d;
                ea_q     <= ea_d;
                eb_q     <= eb_d;
                ma_q     <= ma_d;
                mb_q     <= mb_d;
                spec_q   <= spec_d;
                spec_z_q <= spec_z_d;
                spec_f_q <= spec_f_d;
            end
            ALIGN: begin
                sl_q <= sl_d;
                ss_q <= ss_d;
                el_q <= el_d;
                gl_q <= gl_d;
                gs_q <= gs_d;
            end
            ADD: begin
                sum_q <= sum_d;
                sgn_q <= sgn_d;
            end
            NORM: begin
                ns_q <= ns_d;
                en_q <= en_d;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_fp_addsub.sv
// Bench for fp_addsub: directed corner cases plus random operands against an
// exact big-integer reference, on a single-precision and a half-precision instance.
module tb_fp_addsub;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] a32, b32, z32;
    logic        sub32, iv32, rdy32, zv32, zr32;
    logic [2:0]  f32;
    logic [15:0] a16, b16, z16;
    logic        sub16, iv16, rdy16, zv16, zr16;
    logic [2:0]  f16;

    int checks = 0;
    int failures = 0;

    fp_addsub u32 (
        .clk(clk), .rst(rst), .a(a32), .b(b32), .op_sub(sub32), .in_valid(iv32),
        .in_ready(rdy32), .z(z32), .z_valid(zv32), .z_ready(zr32), .flags(f32)
    );

    fp_addsub #(.EXP_W(5), .MAN_W(10)) u16 (
        .clk(clk), .rst(rst), .a(a16), .b(b16), .op_sub(sub16), .in_valid(iv16),
        .in_ready(rdy16), .z(z16), .z_valid(zv16), .z_ready(zr16), .flags(f16)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Exact reference: operands become integers in units of the smallest denormal,
    // are summed exactly, then rounded to nearest even into the target format.
    task automatic ref_add(input logic [63:0] a, input logic [63:0] b, input bit sub,
                           input int ew, input int mw,
                           output logic [63:0] z, output logic [2:0] fl);
        logic [63:0]  fm, fa, fb, qnan, infm;
        logic [299:0] one, ma, mb, mag, keep, rem, half;
        int           e_a, e_b, maxe, p, sh, ex;
        bit           sa, sb, s, nan_a, nan_b, snan, inf_a, inf_b;
        one  = 1;
        fm   = (64'd1 << mw) - 1;
        maxe = (1 << ew) - 1;
        fa   = a & fm;
        fb   = b & fm;
        e_a  = int'((a >> mw) & ((64'd1 << ew) - 1));
        e_b  = int'((b >> mw) & ((64'd1 << ew) - 1));
        sa   = a[ew+mw];
        sb   = b[ew+mw] ^ sub;
        qnan = (64'(maxe) << mw) | (64'd1 << (mw - 1));
        infm = 64'(maxe) << mw;
        nan_a = (e_a == maxe) && (fa != 0);
        nan_b = (e_b == maxe) && (fb != 0);
        inf_a = (e_a == maxe) && (fa == 0);
        inf_b = (e_b == maxe) && (fb == 0);
        snan  = (nan_a && fa[mw-1] == 1'b0) || (nan_b && fb[mw-1] == 1'b0);
        fl = 3'b000;
        if (nan_a || nan_b) begin
            z  = qnan;
            fl = {snan, 2'b00};
        end else if (inf_a && inf_b) begin
            if (sa == sb) z = (64'(sa) << (ew + mw)) | infm;
            else begin
                z  = qnan;
                fl = 3'b100;
            end
        end else if (inf_a || inf_b) begin
            z = (64'(inf_a ? sa : sb) << (ew + mw)) | infm;
        end else begin
            ma = 300'(fa | ((e_a != 0) ? (64'd1 << mw) : 64'd0));
            mb = 300'(fb | ((e_b != 0) ? (64'd1 << mw) : 64'd0));
            if (e_a > 1) ma = ma << (e_a - 1);
            if (e_b > 1) mb = mb << (e_b - 1);
            if (sa == sb)     begin mag = ma + mb; s = sa; end
            else if (ma > mb) begin mag = ma - mb; s = sa; end
            else if (mb > ma) begin mag = mb - ma; s = sb; end
            else              begin mag = '0;      s = sa & sb; end
            p = -1;
            for (int i = 0; i < 300; i++) if (mag[i]) p = i;
            ex = p - mw + 1;
            if (ex < 1) begin
                z = (64'(s) << (ew + mw)) | mag[63:0];
            end else begin
                sh   = p - mw;
                keep = mag >> sh;
                rem  = mag & ((one << sh) - 1);
                half = (sh > 0) ? (one << (sh - 1)) : '0;
                if (sh > 0 && (rem > half || (rem == half && keep[0]))) keep = keep + 1;
                if (keep == (one << (mw + 1))) begin
                    keep = keep >> 1;
                    ex++;
                end
                if (ex >= maxe) begin
                    z  = (64'(s) << (ew + mw)) | infm;
                    fl = 3'b011;
                end else begin
                    z  = (64'(s) << (ew + mw)) | (64'(ex) << mw) | (keep[63:0] & fm);
                    fl = {2'b00, (rem != 0)};
                end
            end
        end
    endtask

    // Launch one operation and count edges from acceptance to z_valid.
    task automatic run_op(input bit h, input logic [31:0] ta, input logic [31:0] tbv, input bit sub,
                          output logic [31:0] rz, output logic [2:0] rf, output int lat);
        @(negedge clk);
        if (h) begin a16 = ta[15:0]; b16 = tbv[15:0]; sub16 = sub; iv16 = 1'b1; end
        else   begin a32 = ta;       b32 = tbv;       sub32 = sub; iv32 = 1'b1; end
        chk(h ? "in_ready16" : "in_ready32", 64'(h ? rdy16 : rdy32), 64'd1);
        @(posedge clk);
        #1;
        iv16 = 1'b0;
        iv32 = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if ((h ? zv16 : zv32) == 1'b1) begin
                lat = i;
                break;
            end
        end
        rz = h ? {16'd0, z16} : z32;
        rf = h ? f16 : f32;
    endtask

    task automatic ack(input bit h);
        @(negedge clk);
        if (h) zr16 = 1'b1; else zr32 = 1'b1;
        @(posedge clk);
        #1;
        zr16 = 1'b0;
        zr32 = 1'b0;
        chk(h ? "zv_drop16" : "zv_drop32", 64'(h ? zv16 : zv32), 64'd0);
    endtask

    task automatic do_check(input bit h, input logic [31:0] ta, input logic [31:0] tbv, input bit sub,
                            input logic [31:0] ez, input logic [2:0] ef, input string tag);
        logic [31:0] rz;
        logic [2:0]  rf;
        int          lat;
        run_op(h, ta, tbv, sub, rz, rf, lat);
        chk({tag, " latency"}, 64'(lat), 64'd6);
        chk({tag, " z"}, 64'(rz), 64'(ez));
        chk({tag, " flags"}, 64'(rf), 64'(ef));
        ack(h);
    endtask

    task automatic check_idle_reset(input string tag);
        chk({tag, " z32"}, 64'(z32), 64'd0);
        chk({tag, " zv32"}, 64'(zv32), 64'd0);
        chk({tag, " rdy32"}, 64'(rdy32), 64'd1);
        chk({tag, " f32"}, 64'(f32), 64'd0);
        chk({tag, " z16"}, 64'(z16), 64'd0);
        chk({tag, " zv16"}, 64'(zv16), 64'd0);
        chk({tag, " rdy16"}, 64'(rdy16), 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb, rz, tmp;
        logic [63:0] ez;
        logic [2:0]  ef, rf;
        int          lat, mode, e;
        bit          sb;

        rst = 1'b1;
        a32 = '0; b32 = '0; sub32 = 1'b0; iv32 = 1'b0; zr32 = 1'b0;
        a16 = '0; b16 = '0; sub16 = 1'b0; iv16 = 1'b0; zr16 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_reset("reset");
        @(negedge clk);
        rst = 1'b0;

        do_check(0, 32'h3F800000, 32'h40000000, 0, 32'h40400000, 3'b000, "1+2");
        do_check(0, 32'h3F800000, 32'h3F800000, 1, 32'h00000000, 3'b000, "1-1");
        do_check(0, 32'h7F800000, 32'hFF800000, 0, 32'h7FC00000, 3'b100, "inf-inf");
        do_check(0, 32'h7F7FFFFF, 32'h7F7FFFFF, 0, 32'h7F800000, 3'b011, "max+max");
        do_check(0, 32'h00000001, 32'h00000001, 0, 32'h00000002, 3'b000, "denorm");
        do_check(0, 32'h3F800000, 32'h33800000, 0, 32'h3F800000, 3'b001, "tie_even");
        do_check(0, 32'h80000000, 32'h00000000, 1, 32'h80000000, 3'b000, "neg0-0");
        do_check(0, 32'h7F800001, 32'h3F800000, 0, 32'h7FC00000, 3'b100, "snan");
        do_check(0, 32'h7FC00000, 32'h3F800000, 0, 32'h7FC00000, 3'b000, "qnan");
        do_check(0, 32'h3F800000, 32'h7F800000, 1, 32'hFF800000, 3'b000, "1-inf");

        // Backpressure: result held while z_ready is low, then a new operation
        // offered on the release edge must wait for the following edge.
        run_op(0, 32'h40400000, 32'h3F800000, 1, rz, rf, lat);
        chk("bp latency", 64'(lat), 64'd6);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp z", 64'(z32), 64'h40000000);
            chk("bp zv", 64'(zv32), 64'd1);
            chk("bp in_ready", 64'(rdy32), 64'd0);
        end
        @(negedge clk);
        zr32 = 1'b1;
        iv32 = 1'b1;
        a32 = 32'h3F800000; b32 = 32'h3F800000; sub32 = 1'b0;
        @(posedge clk);
        #1;
        zr32 = 1'b0;
        chk("bp no_same_edge_accept", 64'(rdy32), 64'd1);
        chk("bp zv_drop", 64'(zv32), 64'd0);
        @(posedge clk);
        #1;
        iv32 = 1'b0;
        chk("bp accepted", 64'(rdy32), 64'd0);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (zv32) begin lat = i; break; end
        end
        chk("bp2 latency", 64'(lat), 64'd6);
        chk("bp2 z", 64'(z32), 64'h40000000);
        ack(0);

        // Reset while the operation sits in ALIGN, with in_valid also high.
        @(negedge clk);
        a32 = 32'h40A00000; b32 = 32'h40A00000; sub32 = 1'b0; iv32 = 1'b1;
        @(posedge clk);
        #1;
        iv32 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        iv32 = 1'b1;
        @(posedge clk);
        #1;
        check_idle_reset("rst_align");
        @(negedge clk);
        rst = 1'b0;
        iv32 = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("rst_align quiet zv", 64'(zv32), 64'd0);
        do_check(0, 32'h40A00000, 32'h3F800000, 0, 32'h40C00000, 3'b000, "after_rst");

        for (int i = 0; i < 300; i++) begin
            ra = $urandom;
            rb = $urandom;
            mode = $urandom_range(0, 9);
            case (mode)
                0: ;
                7: rb = ($urandom_range(0, 1) == 1) ? ra : {~ra[31], ra[30:0]};
                8: begin
                    ra[30:23] = 8'hFF;
                    if ($urandom_range(0, 1) == 1) ra[22:0] = '0;
                end
                9: begin
                    ra[30:23] = '0;
                    rb[30:23] = '0;
                end
                default: begin
                    e = int'(ra[30:23]) + int'($urandom_range(0, 50)) - 25;
                    if (e < 0) e = 0;
                    if (e > 254) e = 254;
                    rb[30:23] = 8'(e);
                end
            endcase
            sb = 1'($urandom_range(0, 1));
            ref_add(64'(ra), 64'(rb), sb, 8, 23, ez, ef);
            do_check(0, ra, rb, sb, ez[31:0], ef, $sformatf("rnd32[%0d] %h%s%h", i, ra, sb ? "-" : "+", rb));
        end

        do_check(1, 32'h3C00, 32'h3C00, 0, 32'h4000, 3'b000, "h 1+1");
        do_check(1, 32'h7BFF, 32'h7BFF, 0, 32'h7C00, 3'b011, "h max+max");
        do_check(1, 32'h0001, 32'h8001, 1, 32'h0002, 3'b000, "h denorm");

        for (int i = 0; i < 200; i++) begin
            tmp = $urandom;
            ra = {16'd0, tmp[15:0]};
            tmp = $urandom;
            rb = {16'd0, tmp[15:0]};
            mode = $urandom_range(0, 9);
            case (mode)
                0: ;
                7: rb = ($urandom_range(0, 1) == 1) ? ra : {16'd0, ~ra[15], ra[14:0]};
                8: begin
                    ra[14:10] = 5'h1F;
                    if ($urandom_range(0, 1) == 1) ra[9:0] = '0;
                end
                9: begin
                    ra[14:10] = '0;
                    rb[14:10] = '0;
                end
                default: begin
                    e = int'(ra[14:10]) + int'($urandom_range(0, 16)) - 8;
                    if (e < 0) e = 0;
                    if (e > 30) e = 30;
                    rb[14:10] = 5'(e);
                end
            endcase
            sb = 1'($urandom_range(0, 1));
            ref_add(64'(ra), 64'(rb), sb, 5, 10, ez, ef);
            do_check(1, ra, rb, sb, ez[31:0], ef, $sformatf("rnd16[%0d] %h%s%h", i, ra[15:0], sb ? "-" : "+", rb[15:0]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fp_addsub.md
FP_ADDSUB -- requirements
Module: fp_addsub

Interface
REQ-001 SHALL take parameter EXP_W, default 8, meaning exponent field width (2..11).
REQ-002 SHALL take parameter MAN_W, default 23, meaning stored fraction width (4..52); word width W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port clk, input, 1, clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have ports a and b, input, W, IEEE-754-format operands.
REQ-006 SHALL have port op_sub, input, 1, operation select: 0 = a+b, 1 = a-b.
REQ-007 SHALL have port in_valid, input, 1, operands and op_sub valid.
REQ-008 SHALL have port in_ready, output, 1, block accepts an operation this cycle.
REQ-009 SHALL have port z, output, W, result.
REQ-010 SHALL have port z_valid, output, 1, z and flags valid.
REQ-011 SHALL have port z_ready, input, 1, consumer accepts the result.
REQ-012 SHALL have port flags, output, 3, sticky-free per-result {invalid, overflow, inexact}.

Function
REQ-013 SHALL implement FSM states IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, OUT; one state per cycle except IDLE and OUT.
REQ-014 SHALL assert in_ready only in IDLE; accept on in_valid&&in_ready, registering a, b, op_sub, and move to UNPACK.
REQ-015 SHALL step UNPACK->ALIGN->ADD->NORM->ROUND->OUT unconditionally; z_valid rises exactly 6 edges after the accepting edge.
REQ-016 SHALL hold z, flags and z_valid stable in OUT until z_valid&&z_ready, then return to IDLE; no new operation is accepted on that same edge.
REQ-017 SHALL, in UNPACK, invert b sign when op_sub=1; treat exponent 0 as denormal (effective exponent 1, hidden bit 0), else hidden bit 1.
REQ-018 SHALL, in ALIGN, right-shift the smaller-exponent significand in one cycle by the exponent difference, saturating at MAN_W+4, retaining guard, round and sticky (OR of all shifted-out bits).
REQ-019 SHALL, in ADD, add magnitudes on equal effective signs; otherwise subtract smaller from larger and take sign of larger; width MAN_W+5 bits including carry.
REQ-020 SHALL, in NORM, right-shift by 1 on carry-out, else left-shift by leading-zero count in one cycle, limited so the exponent does not fall below 1 (denormal result).
REQ-021 SHALL, in ROUND, round to nearest, ties to even; mantissa carry-out increments exponent.
REQ-022 SHALL return canonical quiet NaN (sign 0, exponent all ones, fraction MSB 1, rest 0) if either input is NaN; invalid set only for signalling-NaN input or inf minus inf.
REQ-023 SHALL return correctly signed infinity for one infinite operand or same-signed infinities, flags 0.
REQ-024 SHALL return +0 for exact cancellation of nonzero operands; -0 only when both effective operands are -0.
REQ-025 SHALL, on exponent reaching all ones after rounding, return signed infinity with overflow=1 and inexact=1.
REQ-026 SHALL set inexact whenever guard|round|sticky is nonzero before rounding.
REQ-027 SHALL pass denormal results with exponent field 0 and no flush-to-zero.

Reset
REQ-028 SHALL, on rst=1, force state IDLE, z_valid=0, in_ready=1 on next cycle, z=0, flags=0, overriding any in-flight operation, which is discarded.
REQ-029 SHALL ignore in_valid in the cycle rst is high.

Verification
REQ-030 SHALL cover default params: a=0x3F800000, b=0x40000000, op_sub=0 -> z=0x40400000, flags=000, z_valid 6 edges after accept.
REQ-031 SHALL cover cancellation: a=b=0x3F800000, op_sub=1 -> z=0x00000000, flags=000.
REQ-032 SHALL cover specials: a=0x7F800000, b=0xFF800000, op_sub=0 -> z=0x7FC00000, invalid=1; a=0x7F7FFFFF plus itself -> z=0x7F800000, overflow=1, inexact=1.
REQ-033 SHALL cover denormals and rounding: 0x00000001+0x00000001 -> 0x00000002; 0x3F800000+0x33800000 -> 0x3F800000, inexact=1 (tie to even).
REQ-034 SHALL cover backpressure and reset: z_ready held 0 for 10 cycles -> z stable, in_ready=0; rst pulsed in ALIGN -> z_valid=0, in_ready=1 next cycle, next operation result correct.
REQ-035 SHALL cover EXP_W=5, MAN_W=10: 0x3C00+0x3C00 -> 0x4000; 0x7BFF+0x7BFF -> 0x7C00, overflow=1.
